// File: rtl/alu_issue.sv
// ============================================================================
// alu_issue : RV32I execute-stage issue register feeding the ALU operands/op
//             through a valid/ready stage with a 2-entry skid buffer.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in_0,
  output logic [XLEN-1:0] alu_in_1,
  output logic [3:0]      alu_op,
  output logic            illegal
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_LSL    = 4'd2;
  localparam logic [3:0] ALU_LT     = 4'd3;
  localparam logic [3:0] ALU_LTU    = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_LSR    = 4'd6;
  localparam logic [3:0] ALU_ASR    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_1 = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] in_0;
    logic [XLEN-1:0] in_1;
    logic [3:0]      op;
    logic            ill;
  } entry_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [3:0]  base_op;
  logic        bad;
  entry_t      dec;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u = {in_instr[31:12], 12'h000};

  // funct3 mapping shared by OP and OP-IMM; the alternate f7 forms are patched below
  always_comb begin
    base_op = ALU_ADD;
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_LSL;
      3'b010:  base_op = ALU_LT;
      3'b011:  base_op = ALU_LTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_LSR;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    dec     = '0;
    dec.op  = ALU_ADD;
    bad     = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.in_0 = in_rs1;
        dec.in_1 = in_rs2;
        if (f7 == F7_ZERO)                    dec.op = base_op;
        else if (f7 == F7_ALT && f3 == 3'b000) dec.op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) dec.op = ALU_ASR;
        else                                   bad    = 1'b1;
      end
      OPC_OPIMM: begin
        dec.in_0 = in_rs1;
        dec.in_1 = XLEN'($signed(imm_i));
        dec.op   = base_op;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.in_1 = XLEN'(in_instr[24:20]);
          if (f3 == 3'b101 && f7 == F7_ALT) dec.op = ALU_ASR;
          else if (f7 != F7_ZERO)           bad    = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.in_1 = XLEN'($signed(imm_u));
        dec.op   = ALU_PASS_1;
      end
      OPC_AUIPC: begin
        dec.in_0 = in_pc;
        dec.in_1 = XLEN'($signed(imm_u));
      end
      OPC_LOAD: begin
        dec.in_0 = in_rs1;
        dec.in_1 = XLEN'($signed(imm_i));
      end
      OPC_STORE: begin
        dec.in_0 = in_rs1;
        dec.in_1 = XLEN'($signed(imm_s));
      end
      OPC_BRANCH: begin
        dec.in_0 = in_rs1;
        dec.in_1 = in_rs2;
        case (f3[2:1])
          2'b00:   dec.op = ALU_SUB;
          2'b10:   dec.op = ALU_LT;
          2'b11:   dec.op = ALU_LTU;
          default: bad    = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        dec.in_0 = in_pc;
        dec.in_1 = XLEN'(4);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec     = '0;
      dec.op  = ALU_ADD;
      dec.ill = 1'b1;
    end
  end

  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   push;
  logic   m_free;

  assign push   = in_valid & in_ready_q;
  assign m_free = ~m_valid_q | out_ready;

  // S is only ever filled while M is held, so refilling M prefers S over the input
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (push) begin
        m_d       = dec;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (push) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end
    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q        <= '0;
      s_q        <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign alu_in_0  = m_q.in_0;
  assign alu_in_1  = m_q.in_1;
  assign alu_op    = m_q.op;
  assign illegal   = m_q.ill;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed literal checks plus randomized traffic against
// a queue-based reference model.
`default_nettype none

module tb_alu_issue;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_LSL    = 4'd2;
  localparam logic [3:0] ALU_LT     = 4'd3;
  localparam logic [3:0] ALU_LTU    = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_LSR    = 4'd6;
  localparam logic [3:0] ALU_ASR    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_1 = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
  logic        in_ready, out_valid, illegal;
  logic [31:0] alu_in_0, alu_in_1;
  logic [3:0]  alu_op;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .alu_op(alu_op), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        ill;
  } exp_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'd0: return ALU_ADD;
      3'd1: return ALU_LSL;
      3'd2: return ALU_LT;
      3'd3: return ALU_LTU;
      3'd4: return ALU_XOR;
      3'd5: return ALU_LSR;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] iu = {ins[31:12], 12'h000};
    bit          ok = 1'b1;
    e.a = 0; e.b = 0; e.op = ALU_ADD; e.ill = 1'b0;
    case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2;
        if (f7 == 7'h00) e.op = f3_op(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_ASR;
        else ok = 1'b0;
      end
      7'h13: begin
        e.a = r1; e.b = ii; e.op = f3_op(f3);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = {27'b0, ins[24:20]};
          if (f3 == 3'd5 && f7 == 7'h20) e.op = ALU_ASR;
          else if (f7 != 7'h00) ok = 1'b0;
        end
      end
      7'h37: begin e.a = 0;  e.b = iu; e.op = ALU_PASS_1; end
      7'h17: begin e.a = pc; e.b = iu; end
      7'h03: begin e.a = r1; e.b = ii; end
      7'h23: begin e.a = r1; e.b = is; end
      7'h63: begin
        e.a = r1; e.b = r2;
        if (f3 == 3'd0 || f3 == 3'd1) e.op = ALU_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) e.op = ALU_LT;
        else if (f3 == 3'd6 || f3 == 3'd7) e.op = ALU_LTU;
        else ok = 1'b0;
      end
      7'h6F, 7'h67: begin e.a = pc; e.b = 32'd4; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin e.a = 0; e.b = 0; e.op = ALU_ADD; e.ill = 1'b1; end
    return e;
  endfunction

  // Reference: the stage behaves as an in-order FIFO of depth two
  exp_t q[$];
  bit   exp_ready = 1'b1;
  bit   exp_rst   = 1'b0;
  bit   mdl_live  = 1'b0;

  always @(posedge clk) begin : model
    bit push, pop;
    if (!rst_n) begin
      q.delete();
      exp_ready = 1'b1;
      exp_rst   = 1'b1;
    end else begin
      exp_rst = 1'b0;
      push = in_valid && exp_ready;
      pop  = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(ref_dec(in_instr, in_pc, in_rs1, in_rs2));
      end
      exp_ready = (q.size() < 2);
    end
    mdl_live = 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_live) begin
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, q.size() > 0);
      if (exp_rst) begin
        chk("rst_in_0", alu_in_0, 0);
        chk("rst_in_1", alu_in_1, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_illegal", illegal, 0);
      end else if (q.size() > 0) begin
        chk("alu_in_0", alu_in_0, q[0].a);
        chk("alu_in_1", alu_in_1, q[0].b);
        chk("alu_op", alu_op, q[0].op);
        chk("illegal", illegal, q[0].ill);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 9) != 0) begin
      case ($urandom_range(0, 8))
        0: w[6:0] = 7'h33;
        1: w[6:0] = 7'h13;
        2: w[6:0] = 7'h37;
        3: w[6:0] = 7'h17;
        4: w[6:0] = 7'h03;
        5: w[6:0] = 7'h23;
        6: w[6:0] = 7'h63;
        7: w[6:0] = 7'h6F;
        default: w[6:0] = 7'h67;
      endcase
      if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  task automatic offer(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; in_instr = ins; in_rs1 = r1; in_rs2 = r2;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = 32'h100;
    offer(32'h002081B3, 32'd9, 32'd9);
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_alu_in_0", alu_in_0, 32'h0);
    chk("reset_alu_op", alu_op, 4'h0);

    e = ref_dec(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk("model_add_op", e.op, ALU_ADD);
    chk("model_add_b", e.b, 32'd7);
    e = ref_dec(32'h4030D093, 32'h0, 32'h80000000, 32'h0);
    chk("model_srai_op", e.op, ALU_ASR);
    chk("model_srai_b", e.b, 32'd3);
    e = ref_dec(32'h00000013 | (32'h800 << 20), 32'h0, 32'h0, 32'h0);
    chk("model_addi_neg", e.b, 32'hFFFFF800);

    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    offer(32'h002081B3, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_valid", out_valid, 1'b1);
    chk("add_op", alu_op, ALU_ADD);
    chk("add_in_0", alu_in_0, 32'd5);
    chk("add_in_1", alu_in_1, 32'd7);
    chk("add_illegal", illegal, 1'b0);
    offer(32'h4030D093, 32'h80000000, 32'h0);
    @(negedge clk);
    chk("srai_op", alu_op, ALU_ASR);
    chk("srai_in_1", alu_in_1, 32'd3);
    chk("srai_in_0", alu_in_0, 32'h80000000);
    offer(32'hFFF08093, 32'd10, 32'h0);
    @(negedge clk);
    chk("addi_in_1", alu_in_1, 32'hFFFFFFFF);
    chk("addi_op", alu_op, ALU_ADD);
    in_valid = 1'b0;
    @(negedge clk);

    out_ready = 1'b0;
    offer(32'h002081B3, 32'd1, 32'd0);
    @(negedge clk);
    chk("stall_a_held", alu_in_0, 32'd1);
    in_rs1 = 32'd2;
    @(negedge clk);
    chk("stall_skid_full", in_ready, 1'b0);
    in_rs1 = 32'd3;
    @(negedge clk);
    chk("stall_c_blocked", in_ready, 1'b0);
    chk("stall_a_stable", alu_in_0, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_b", alu_in_0, 32'd2);
    chk("drain_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("drain_c", alu_in_0, 32'd3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_empty", out_valid, 1'b0);

    out_ready = 1'b0;
    offer(32'h002081B3, 32'd4, 32'd0);
    @(negedge clk);
    in_rs1 = 32'd5;
    @(negedge clk);
    chk("flush_pre_full", in_ready, 1'b0);
    flush = 1'b1; in_rs1 = 32'd6;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_stays_empty", out_valid, 1'b0);
    flush = 1'b1; offer(32'h002081B3, 32'd7, 32'd0);
    @(negedge clk);
    chk("flush_drops_input", out_valid, 1'b0);
    flush = 1'b0;

    offer(32'hFFFFFFFF, 32'd5, 32'd5);
    @(negedge clk);
    chk("ill_all_ones", illegal, 1'b1);
    chk("ill_all_ones_op", alu_op, ALU_ADD);
    chk("ill_all_ones_in_0", alu_in_0, 32'h0);
    chk("ill_all_ones_in_1", alu_in_1, 32'h0);
    offer(32'h4000F033, 32'd5, 32'd5);
    @(negedge clk);
    chk("ill_op_f7", illegal, 1'b1);
    chk("ill_op_f7_op", alu_op, ALU_ADD);
    chk("ill_op_f7_in_0", alu_in_0, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      in_rs1    = $urandom;
      in_rs2    = $urandom;
      @(negedge clk);
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Execute-stage issue register that drives the ALU operand/operation interface: in_0, in_1 and the 4-bit operation code.
- Decodes an RV32I instruction plus its register/PC values into ALU_* codes from alu_codes.h and the selected operands.
- Presents the result to the ALU through a valid/ready pipeline stage with a 2-entry skid buffer, giving full throughput, registered in_ready and in-order delivery.

Parameters:
- XLEN, 32, datapath width; equals the XLEN in riscv.h.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous pipeline flush (branch redirect).
- in_valid  in  1  decode stage offers an instruction.
- in_ready  out  1  issue stage can accept; registered.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- in_rs1  in  XLEN  rs1 register value.
- in_rs2  in  XLEN  rs2 register value.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream consumes this cycle.
- alu_in_0  out  XLEN  ALU first operand.
- alu_in_1  out  XLEN  ALU second operand.
- alu_op  out  4  ALU operation code (ALU_* from alu_codes.h).
- illegal  out  1  entry carries an undecodable instruction.

Behaviour:

Reset and handshake:
- Reset (rst_n=0 at clk edge): both entries invalid; out_valid=0; in_ready=1; alu_in_0, alu_in_1, alu_op and illegal all 0.
- Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- Storage: main entry M drives the outputs; skid entry S. Decode happens before storage, so stored entries are already decoded.
- Latency: an instruction accepted with M empty appears on the outputs the next cycle.
- Accept with M empty, or M draining this cycle: the instruction goes to M. Accept while M is held (out_valid & !out_ready): it goes to S.
- in_ready(next) = !S_valid(next). With S full and M draining, S moves to M and in_ready returns to 1 the following cycle.
- Order is strictly preserved. Outputs stay stable while out_valid & !out_ready.
- Back-to-back with out_ready=1 sustains one instruction per cycle.

Flush:
- flush=1: both entries invalidated at the edge; in_ready=1 next cycle.
- flush beats a simultaneous input transfer: that instruction is dropped.
- Data outputs may hold stale values, but out_valid=0.

Decode (opc = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]; immediates sign-extended I/S/B/U/J per RV32I):
- OP (0110011): in_0=rs1, in_1=rs2. f3/f7 map to ADD/SUB/SLL→LSL/SLT→LT/SLTU→LTU/XOR/SRL→LSR/SRA→ASR/OR/AND. f7 must be 0000000, or 0100000 only for SUB/SRA; otherwise illegal.
- OP-IMM (0010011): in_0=rs1, in_1=immI. Shifts use in_1={27'b0,instr[24:20]}; f7 rules as OP, with 0100000 allowed for SRAI only. SUB is never generated.
- LUI: in_0=0, in_1=immU, op=PASS_1.
- AUIPC: in_0=pc, in_1=immU, op=ADD.
- LOAD (0000011): in_0=rs1, in_1=immI, op=ADD.
- STORE (0100011): in_0=rs1, in_1=immS, op=ADD.
- BRANCH (1100011): in_0=rs1, in_1=rs2. f3 000/001 → SUB, 100/101 → LT, 110/111 → LTU, 010/011 → illegal.
- JAL and JALR: in_0=pc, in_1=4, op=ADD (link value).
- Any other opcode, or a malformed field: illegal=1, op=ADD, in_0=in_1=0. The entry still flows through the handshake like a normal instruction.

Test Plan:
- Reset with flush=0 and in_valid=1 held: out_valid=0, in_ready=1, all data outputs 0 while rst_n=0.
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, op=ADD, in_0=5, in_1=7, illegal=0.
- SRAI (0x4030D093), rs1=0x80000000 → op=ASR, in_1=3. ADDI -1 (0xFFF08093) → in_1=0xFFFFFFFF.
- Stall: out_ready=0, issue A, B, C back-to-back → A held on outputs, B in skid, in_ready=0 before C is accepted. Raise out_ready → A, B, C emerge in order, one per cycle.
- flush asserted together with a new in_valid while skid is full → next cycle out_valid=0, in_ready=1; the new instruction never appears.
- Illegal word 0xFFFFFFFF, then OP with f7=0100000, f3=111 → both illegal=1, op=ADD, operands 0.
